alu_shift_unit: RTL and testbench
=================================

Name: alu_shift_unit

Overview:
- Multi-cycle shifter for the RISC ALU datapath.
- Shifts or rotates a WIDTH-bit operand by one bit per clock, controlled by a start/busy/done handshake.
- `result` feeds one data input of the ALU's 2:1 result-select mux, which is the downstream consumer.
- The control unit pulses `start`, waits for `done`, then steers the mux select to pick the shifter output.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled on rising edge of clk; accepted only in IDLE or DONE.
- op, input, 2, operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- a, input, WIDTH, operand; captured when start is accepted.
- shamt, input, SHW, shift amount N (0..WIDTH-1); captured when start is accepted.
- busy, output, 1, high while shifting.
- done, output, 1, one-cycle pulse; result is final while done is high.
- result, output, WIDTH, shifter output register.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - FSM goes to IDLE.
  - busy=0, done=0, result=0, internal count=0, latched op=00.
  - Takes effect immediately, without waiting for a clock edge.
  - Any in-flight operation is discarded; no done is produced for it.
- State register encodings: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0, result holds its last value.
  - If start=1 at edge k: result<=a, op_r<=op, cnt<=shamt, go to SHIFT.
- SHIFT:
  - busy=1, done=0.
  - Each edge with cnt!=0: shift result by one bit per op_r, then cnt<=cnt-1.
    - SLL: {result[WIDTH-2:0],1'b0}
    - SRL: {1'b0,result[WIDTH-1:1]}
    - SRA: {result[WIDTH-1],result[WIDTH-1:1]}
    - ROR: {result[0],result[WIDTH-1:1]}
  - Edge with cnt==0: no shift; go to DONE.
  - start is ignored in SHIFT; operands are not re-captured.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: if start=1, behave exactly as the IDLE accept (back-to-back operation, no bubble). Otherwise go to IDLE.
- Latency:
  - start sampled at edge k; shifts on edges k+1..k+N; DONE entered at edge k+N+1.
  - done is high in the cycle following edge k+N+1.
  - busy is high from after edge k until after edge k+N+1, i.e. N+1 cycles.
  - N=0 gives busy for 1 cycle, then done with result=a.
- Result stability:
  - result is final from entry to DONE until the next accepted start.
  - During SHIFT, result holds intermediate values that are not valid for consumers.
- Width rules:
  - shamt is unsigned; all shifts are logical on WIDTH bits, except SRA, which replicates bit WIDTH-1.
  - There is no overflow or carry output.
- Boundary conditions:
  - shamt=WIDTH-1 is the maximum and takes WIDTH cycles to done.
  - start held high continuously gives back-to-back operations; each accept re-samples a/op/shamt in IDLE or DONE only.
  - Changes on a/op/shamt after the accept edge have no effect.
  - Reset asserted in the same cycle as start: reset wins.

Test Plan:
1. SLL, WIDTH=32, a=0x00000001, shamt=4, start at edge 0 -> busy high edges 1..5, done high after edge 5, result=0x00000010; FSM back in IDLE after edge 6.
2. SRA a=0x80000000 shamt=31 -> result=0xFFFFFFFF, done after edge 32. Repeat with SRL -> result=0x00000001. Repeat with ROR a=0x00000001 shamt=1 -> result=0x80000000, done after edge 2.
3. shamt=0, op=SLL, a=0xDEADBEEF -> busy for 1 cycle, done after edge 1, result=0xDEADBEEF.
4. Busy and back-to-back start:
   - Start SRL a=0x0000F000 shamt=8; pulse start with a=0xFFFFFFFF at edge 3 (while busy) -> ignored; done after edge 9 with result=0x000000F0.
   - Start asserted in the DONE cycle (op=SLL, a=0x1, shamt=2) -> accepted with no IDLE cycle; done 3 edges later, result=0x4.
5. Reset mid-op: SLL a=0x1 shamt=20, drop rst_n between edges 5 and 6 -> busy=0, done=0, result=0 immediately, with no clock edge needed. After release, no done for the aborted op; a new start (SRA a=0xF0000000 shamt=4) completes normally -> result=0xFF000000.

Source files
------------

// File: rtl/alu_shift_unit.sv
// Multi-cycle shifter for the ALU datapath: SLL/SRL/SRA/ROR, one bit per clock,
// with a start/busy/done handshake feeding the ALU result-select mux.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; result holds its last value
// SHIFT | down-counting cnt, shifting result one bit per edge while cnt!=0
// DONE  | one-cycle done pulse; result final; start here restarts directly
module alu_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [SHW-1:0]   cnt;
  logic             cnt_zero;
  logic             accept;
  logic [WIDTH-1:0] shift_one;

  assign cnt_zero = (cnt == '0);
  // start is only honoured when no operation is in flight
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded straight from the state register so reset clears them at once
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_comb begin
    shift_one = result;
    case (op_r)
      OP_SLL:  shift_one = {result[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, result[WIDTH-1:1]};
      OP_SRA:  shift_one = {result[WIDTH-1], result[WIDTH-1:1]};
      OP_ROR:  shift_one = {result[0], result[WIDTH-1:1]};
      default: shift_one = result;
    endcase
  end

  // datapath: capture on accept, then one bit per edge until the count expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      op_r   <= OP_SLL;
      cnt    <= '0;
    end else if (accept) begin
      result <= a;
      op_r   <= op;
      cnt    <= shamt;
    end else if ((state == SHIFT) && !cnt_zero) begin
      result <= shift_one;
      cnt    <= cnt - SHW'(1);
    end
  end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Self-checking bench for alu_shift_unit: directed plan cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  alu_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input int n);
    logic [31:0] r;
    case (o)
      2'b00:   r = v << n;
      2'b01:   r = v >> n;
      2'b10:   r = $signed(v) >>> n;
      default: r = (n == 0) ? v : ((v >> n) | (v << (32 - n)));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a clock edge. Start is sampled on the next edge; on
  // return we sit #1 after the edge that enters DONE. poke>=0 pulses start
  // with all-ones data before edge k+1+poke to show it is ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] v, input int n,
                        input int poke, input string tag);
    logic [31:0] exp;
    exp   = model(o, v, n);
    start = 1'b1;
    op    = o;
    a     = v;
    shamt = 5'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    shamt = 5'($urandom);
    for (int j = 0; j <= n; j++) begin
      chk({tag, " busy"}, {30'd0, busy, done}, 32'h2);
      if (j == poke) begin
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk({tag, " done"}, {30'd0, busy, done}, 32'h1);
    chk({tag, " result"}, result, exp);
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_res);
    @(posedge clk);
    #1;
    chk({tag, " idle"}, {30'd0, busy, done}, 32'h0);
    chk({tag, " hold"}, result, exp_res);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    int          rn;
    logic [31:0] last;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    shamt = '0;
    #3;
    chk("reset outputs", {busy, done, 30'd0}, 32'h0);
    chk("reset result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // plan 1-3
    run_op(2'b00, 32'h0000_0001, 4, -1, "sll4");
    chk("sll4 literal", result, 32'h0000_0010);
    chk_idle("sll4", 32'h0000_0010);
    run_op(2'b10, 32'h8000_0000, 31, -1, "sra31");
    chk("sra31 literal", result, 32'hFFFF_FFFF);
    chk_idle("sra31", 32'hFFFF_FFFF);
    run_op(2'b01, 32'h8000_0000, 31, -1, "srl31");
    chk("srl31 literal", result, 32'h0000_0001);
    chk_idle("srl31", 32'h0000_0001);
    run_op(2'b11, 32'h0000_0001, 1, -1, "ror1");
    chk("ror1 literal", result, 32'h8000_0000);
    chk_idle("ror1", 32'h8000_0000);
    run_op(2'b00, 32'hDEAD_BEEF, 0, -1, "zero");
    chk("zero literal", result, 32'hDEAD_BEEF);
    chk_idle("zero", 32'hDEAD_BEEF);

    // plan 4: start while busy ignored, then start in DONE accepted back-to-back
    run_op(2'b01, 32'h0000_F000, 8, 2, "busy_ign");
    chk("busy_ign literal", result, 32'h0000_00F0);
    run_op(2'b00, 32'h0000_0001, 2, -1, "b2b");
    chk("b2b literal", result, 32'h0000_0004);
    chk_idle("b2b", 32'h0000_0004);

    // plan 5: asynchronous reset mid-operation
    start = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst outputs", {30'd0, busy, done}, 32'h0);
    chk("async rst result", result, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(posedge clk);
      #1;
      chk("no done after abort", {30'd0, busy, done}, 32'h0);
    end
    run_op(2'b10, 32'hF000_0000, 4, -1, "post_rst");
    chk("post_rst literal", result, 32'hFF00_0000);
    chk_idle("post_rst", 32'hFF00_0000);

    // reset wins over a coincident start
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; shamt = 5'd3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst vs start", {busy, done, 30'd0}, 32'h0);
    chk("rst vs start result", result, 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    last = 32'h0;

    // randomized operations, mixing idle gaps with back-to-back starts
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rn = (i % 8 == 0) ? ((i % 16 == 0) ? 31 : 0) : int'($urandom_range(0, 31));
      run_op(ro, ra, rn, -1, $sformatf("rand%0d", i));
      last = model(ro, ra, rn);
      if ($urandom_range(0, 1) == 1) chk_idle($sformatf("rand%0d", i), last);
    end
    chk_idle("final", last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
